dht11_request_controller: RTL and testbench

DHT11_REQUEST_CONTROLLER -- requirements
Module: dht11_request_controller

---
 rtl/dht11_ctrl_pkg.sv | 45 ++++
 rtl/dht11_interval_timer.sv | 35 +++
 rtl/dht11_request_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_dht11_request_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_ctrl_pkg
// Purpose  : Command/response codes, state encodings and frame checksum
//            helper shared by the DHT11 request controller.
// Revision : 1.0 - initial release
// ============================================================================
package dht11_ctrl_pkg;

    localparam logic [7:0] c_CMD_STATUS    = 8'h00;
    localparam logic [7:0] c_CMD_READ_TEMP = 8'h01;
    localparam logic [7:0] c_CMD_READ_HUM  = 8'h02;
    localparam logic [7:0] c_CMD_CONT_TEMP = 8'h03;
    localparam logic [7:0] c_CMD_CONT_HUM  = 8'h04;
    localparam logic [7:0] c_CMD_STOP      = 8'h05;

    localparam logic [7:0] c_RSP_OK        = 8'h07;
    localparam logic [7:0] c_RSP_HUM       = 8'h08;
    localparam logic [7:0] c_RSP_TEMP      = 8'h09;
    localparam logic [7:0] c_RSP_STOPPED   = 8'h0A;
    localparam logic [7:0] c_RSP_ERROR     = 8'h1F;
    localparam logic [7:0] c_RSP_BUSY      = 8'hFE;
    localparam logic [7:0] c_RSP_INVALID   = 8'hFF;

    localparam int c_ST_W = 3;
    typedef logic [c_ST_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_GAP_WAIT  = 3'd1;
    localparam state_t c_ST_START     = 3'd2;
    localparam state_t c_ST_WAIT_DONE = 3'd3;
    localparam state_t c_ST_RELEASE   = 3'd4;
    localparam state_t c_ST_CHECK     = 3'd5;
    localparam state_t c_ST_RESPOND   = 3'd6;
    localparam state_t c_ST_CONT_WAIT = 3'd7;

    // Frame is {hum_int, hum_dec, temp_int, temp_dec, checksum}.
    function automatic logic checksum_ok(input logic [39:0] frame);
        logic [7:0] w_sum;
        w_sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return (w_sum == frame[7:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : dht11_interval_timer
// Purpose  : Saturating cycle counter with clear/enable and a reached flag.
// Revision : 1.0 - initial release
// ============================================================================
module dht11_interval_timer #(
    parameter int LIMIT = 100,
    parameter int WIDTH = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_reached
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count < c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_reached = (r_count >= c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/dht11_request_controller.sv
`default_nettype none
// ============================================================================
// Module   : dht11_request_controller
// Purpose  : Command/response front end that paces DHT11 reads, validates
//            frames and supports continuous temperature/humidity reporting.
// Revision : 1.0 - initial release
// ============================================================================
module dht11_request_controller
    import dht11_ctrl_pkg::*;
#(
    parameter int MIN_GAP_CYCLES = 100_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [7:0]  req_cmd,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_code,
    output logic [7:0]  rsp_data,
    output logic        sensor_enable,
    input  logic [39:0] sensor_data,
    input  logic        sensor_erro,
    input  logic        sensor_done
);

    localparam int c_GAP_W = $clog2(MIN_GAP_CYCLES + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cmd;
    logic        r_cont;
    logic [39:0] r_frame;
    logic        r_erro;
    logic        r_timeout;
    logic        r_req_ready;
    logic        r_sensor_enable;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_code;
    logic [7:0]  r_rsp_data;

    logic        w_accept;
    logic        w_gap_reached;
    logic        w_to_reached;
    logic        w_load_rsp;
    logic [7:0]  w_rsp_code;
    logic [7:0]  w_rsp_data;
    logic        w_cont_set;
    logic        w_cont_clr;
    logic        w_latch;
    logic        w_timeout_hit;
    logic        w_check_err;

    assign w_accept = req_valid && r_req_ready;

    // Gap timer free-runs and is restarted only when a sensor read finishes.
    dht11_interval_timer #(
        .LIMIT (MIN_GAP_CYCLES),
        .WIDTH (c_GAP_W)
    ) u_gap_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (r_state == c_ST_RELEASE),
        .i_enable  (1'b1),
        .o_reached (w_gap_reached)
    );

    dht11_interval_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (c_TO_W)
    ) u_timeout_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (r_state != c_ST_WAIT_DONE),
        .i_enable  (r_state == c_ST_WAIT_DONE),
        .o_reached (w_to_reached)
    );

    always_comb begin
        w_next_state  = r_state;
        w_load_rsp    = 1'b0;
        w_rsp_code    = r_rsp_code;
        w_rsp_data    = 8'h00;
        w_cont_set    = 1'b0;
        w_cont_clr    = 1'b0;
        w_latch       = 1'b0;
        w_timeout_hit = 1'b0;
        w_check_err   = r_erro || r_timeout || !checksum_ok(r_frame);

        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (req_cmd <= c_CMD_CONT_HUM) begin
                        w_next_state = c_ST_GAP_WAIT;
                        w_cont_set   = (req_cmd == c_CMD_CONT_TEMP) ||
                                       (req_cmd == c_CMD_CONT_HUM);
                    end else begin
                        w_next_state = c_ST_RESPOND;
                        w_load_rsp   = 1'b1;
                        w_rsp_code   = c_RSP_INVALID;
                    end
                end
            end
            c_ST_GAP_WAIT: begin
                if (w_gap_reached) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                w_next_state = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                if (sensor_done) begin
                    w_latch      = 1'b1;
                    w_next_state = c_ST_RELEASE;
                end else if (w_to_reached) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                w_next_state = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                w_next_state = c_ST_RESPOND;
                w_load_rsp   = 1'b1;
                if (w_check_err) begin
                    w_rsp_code = c_RSP_ERROR;
                end else if (r_cmd == c_CMD_STATUS) begin
                    w_rsp_code = c_RSP_OK;
                end else if ((r_cmd == c_CMD_READ_TEMP) || (r_cmd == c_CMD_CONT_TEMP)) begin
                    w_rsp_code = c_RSP_TEMP;
                    w_rsp_data = r_frame[23:16];
                end else begin
                    w_rsp_code = c_RSP_HUM;
                    w_rsp_data = r_frame[39:32];
                end
            end
            c_ST_RESPOND: begin
                if (rsp_ready) begin
                    w_next_state = r_cont ? c_ST_CONT_WAIT : c_ST_IDLE;
                end
            end
            c_ST_CONT_WAIT: begin
                // A pending request wins over an expiring gap.
                if (w_accept) begin
                    w_next_state = c_ST_RESPOND;
                    w_load_rsp   = 1'b1;
                    if (req_cmd == c_CMD_STOP) begin
                        w_cont_clr = 1'b1;
                        w_rsp_code = c_RSP_STOPPED;
                    end else begin
                        w_rsp_code = c_RSP_BUSY;
                    end
                end else if (w_gap_reached) begin
                    w_next_state = c_ST_START;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= c_ST_IDLE;
            r_cmd           <= 8'h00;
            r_cont          <= 1'b0;
            r_frame         <= 40'h0;
            r_erro          <= 1'b0;
            r_timeout       <= 1'b0;
            r_req_ready     <= 1'b0;
            r_sensor_enable <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_code      <= 8'h00;
            r_rsp_data      <= 8'h00;
        end else begin
            r_state         <= w_next_state;
            r_req_ready     <= (w_next_state == c_ST_IDLE) || (w_next_state == c_ST_CONT_WAIT);
            r_sensor_enable <= (w_next_state == c_ST_START) || (w_next_state == c_ST_WAIT_DONE);

            if ((r_state == c_ST_IDLE) && w_accept) begin
                r_cmd <= req_cmd;
            end

            if (w_cont_set) begin
                r_cont <= 1'b1;
            end else if (w_cont_clr) begin
                r_cont <= 1'b0;
            end

            if (r_state == c_ST_START) begin
                r_erro    <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_latch) begin
                r_frame <= sensor_data;
                r_erro  <= sensor_erro;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end

            if (w_load_rsp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_code  <= w_rsp_code;
                r_rsp_data  <= w_rsp_data;
            end else if ((r_state == c_ST_RESPOND) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready     = r_req_ready;
    assign sensor_enable = r_sensor_enable;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_code      = r_rsp_code;
    assign rsp_data      = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_dht11_request_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_request_controller
// Purpose  : Directed self-checking bench with a behavioural DHT11 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dht11_request_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_cmd = 8'h00;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_code;
    logic [7:0]  rsp_data;
    logic        sensor_enable;
    logic [39:0] sensor_data = 40'h0;
    logic        sensor_erro = 1'b0;
    logic        sensor_done = 1'b0;

    always #5 clock = ~clock;

    dht11_request_controller #(
        .MIN_GAP_CYCLES (100),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_code      (rsp_code),
        .rsp_data      (rsp_data),
        .sensor_enable (sensor_enable),
        .sensor_data   (sensor_data),
        .sensor_erro   (sensor_erro),
        .sensor_done   (sensor_done)
    );

    // Sensor answers a few cycles after enable; done/erro stay sticky until enable drops.
    logic [39:0] model_frame   = 40'h0;
    logic        model_erro    = 1'b0;
    logic        model_no_done = 1'b0;
    int          model_cnt     = 0;

    always @(posedge clock) begin
        if (!sensor_enable) begin
            model_cnt   <= 0;
            sensor_done <= 1'b0;
            sensor_erro <= 1'b0;
            sensor_data <= 40'h0;
        end else begin
            model_cnt <= model_cnt + 1;
            if (!model_no_done && (model_cnt == 4)) begin
                sensor_done <= 1'b1;
                sensor_erro <= model_erro;
                sensor_data <= model_frame;
            end
        end
    end

    int   cyc       = 0;
    int   rises     = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    logic prev_en   = 1'b0;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        prev_en <= sensor_enable;
        if (sensor_enable && !prev_en) begin
            rises     <= rises + 1;
            last_rise <= cyc;
        end
        if (!sensor_enable && prev_en) begin
            last_fall <= cyc;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if ((act < lo) || (act > hi)) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // All tasks are entered and left at a falling edge.
    task automatic send_cmd(input logic [7:0] cmd);
        int n = 0;
        req_cmd   = cmd;
        req_valid = 1'b1;
        while (!req_ready && (n < 1000)) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("req_accept_%02h", cmd), {63'h0, req_ready}, 64'h1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && (n < 600)) begin
            @(negedge clock);
            n++;
        end
        check("rsp_arrives", {63'h0, rsp_valid}, 64'h1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_drop", {63'h0, rsp_valid}, 64'h0);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [39:0] frame;
        logic        erro;
        logic        no_done;
        logic [7:0]  exp_code;
        logic [7:0]  exp_data;
        logic        exp_sense;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int rel_cyc;
        int r0;
        int r1;
        int r2;
        int r3;
        int n;

        vecs[0] = '{8'h02, 40'h37_00_1A_00_51, 1'b0, 1'b0, 8'h08, 8'h37, 1'b1};
        vecs[1] = '{8'h01, 40'h37_00_1A_00_50, 1'b0, 1'b0, 8'h1F, 8'h00, 1'b1};
        vecs[2] = '{8'h01, 40'h37_00_1A_00_51, 1'b0, 1'b0, 8'h09, 8'h1A, 1'b1};
        vecs[3] = '{8'h00, 40'h37_00_1A_00_51, 1'b0, 1'b0, 8'h07, 8'h00, 1'b1};
        vecs[4] = '{8'h00, 40'h37_00_1A_00_51, 1'b1, 1'b0, 8'h1F, 8'h00, 1'b1};
        vecs[5] = '{8'h05, 40'h37_00_1A_00_51, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};
        vecs[6] = '{8'h02, 40'h5A_10_20_05_8F, 1'b0, 1'b0, 8'h08, 8'h5A, 1'b1};
        vecs[7] = '{8'h01, 40'hFF_01_02_03_05, 1'b0, 1'b0, 8'h09, 8'h02, 1'b1};

        repeat (3) @(negedge clock);
        check("rst_sensor_enable", {63'h0, sensor_enable}, 64'h0);
        check("rst_rsp_valid",     {63'h0, rsp_valid},     64'h0);
        check("rst_rsp_code",      {56'h0, rsp_code},      64'h0);
        check("rst_rsp_data",      {56'h0, rsp_data},      64'h0);
        check("rst_req_ready",     {63'h0, req_ready},     64'h0);
        reset   = 1'b1;
        rel_cyc = cyc;
        @(negedge clock);
        check("idle_req_ready", {63'h0, req_ready}, 64'h1);

        for (int i = 0; i < 8; i++) begin
            model_frame   = vecs[i].frame;
            model_erro    = vecs[i].erro;
            model_no_done = vecs[i].no_done;
            r0 = rises;
            send_cmd(vecs[i].cmd);
            wait_rsp();
            check($sformatf("v%0d_code", i), {56'h0, rsp_code}, {56'h0, vecs[i].exp_code});
            check($sformatf("v%0d_data", i), {56'h0, rsp_data}, {56'h0, vecs[i].exp_data});
            check($sformatf("v%0d_sense", i), {63'h0, (rises != r0)}, {63'h0, vecs[i].exp_sense});
            if (i == 0) begin
                check_range("first_gap", last_rise - rel_cyc, 100, 1000);
            end
            ack_rsp();
        end

        // Sensor never answers: enable stays up for the timeout window.
        model_no_done = 1'b1;
        model_erro    = 1'b0;
        send_cmd(8'h01);
        wait_rsp();
        check("timeout_code", {56'h0, rsp_code}, 64'h1F);
        check("timeout_data", {56'h0, rsp_data}, 64'h00);
        check_range("timeout_enable_len", last_fall - last_rise, 50, 53);
        check("timeout_enable_low", {63'h0, sensor_enable}, 64'h0);
        ack_rsp();
        model_no_done = 1'b0;

        // Invalid command, response held while the consumer stalls.
        r0 = rises;
        send_cmd(8'h42);
        wait_rsp();
        check("inv_code", {56'h0, rsp_code}, 64'hFF);
        check("inv_data", {56'h0, rsp_data}, 64'h00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("inv_hold_%0d", k), {47'h0, rsp_valid, rsp_code, rsp_data}, {47'h0, 1'b1, 8'hFF, 8'h00});
        end
        check("inv_no_sense", rises, r0);
        ack_rsp();

        // Continuous temperature, one errored read in the middle.
        model_frame = 40'h37_00_1A_00_51;
        send_cmd(8'h03);
        wait_rsp();
        check("cont1_code", {56'h0, rsp_code}, 64'h09);
        check("cont1_data", {56'h0, rsp_data}, 64'h1A);
        r1 = last_rise;
        ack_rsp();
        model_erro = 1'b1;
        wait_rsp();
        check("cont2_code", {56'h0, rsp_code}, 64'h1F);
        check("cont2_data", {56'h0, rsp_data}, 64'h00);
        r2 = last_rise;
        check_range("cont_spacing_1", r2 - r1, 100, 400);
        ack_rsp();
        model_erro = 1'b0;
        wait_rsp();
        check("cont3_code", {56'h0, rsp_code}, 64'h09);
        check("cont3_data", {56'h0, rsp_data}, 64'h1A);
        r3 = last_rise;
        check_range("cont_spacing_2", r3 - r2, 100, 400);
        ack_rsp();
        send_cmd(8'h01);
        wait_rsp();
        check("busy_code", {56'h0, rsp_code}, 64'hFE);
        check("busy_data", {56'h0, rsp_data}, 64'h00);
        ack_rsp();
        send_cmd(8'h05);
        wait_rsp();
        check("stop_code", {56'h0, rsp_code}, 64'h0A);
        check("stop_data", {56'h0, rsp_data}, 64'h00);
        ack_rsp();
        r0 = rises;
        repeat (300) @(negedge clock);
        check("stop_no_sense", rises, r0);
        check("stop_idle_ready", {63'h0, req_ready}, 64'h1);

        // Reset while the sensor is being read.
        model_no_done = 1'b1;
        send_cmd(8'h01);
        n = 0;
        while (!sensor_enable && (n < 400)) begin
            @(negedge clock);
            n++;
        end
        check("mid_enable_up", {63'h0, sensor_enable}, 64'h1);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_enable", {63'h0, sensor_enable}, 64'h0);
        check("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        reset         = 1'b1;
        rel_cyc       = cyc;
        model_no_done = 1'b0;
        send_cmd(8'h02);
        wait_rsp();
        check("post_rst_code", {56'h0, rsp_code}, 64'h08);
        check("post_rst_data", {56'h0, rsp_data}, 64'h37);
        check_range("post_rst_gap", last_rise - rel_cyc, 100, 1000);
        ack_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
